// File: rtl/lsu_pkg.sv
// lsu_pkg: size and state encodings shared by the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE, ERR} state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane extract/extend for loads, lane merge for stores, alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        uns,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lo,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misaligned
);
    logic [4:0]  sh;
    logic [31:0] lane, mask;
    assign sh = (size == SZ_HALF) ? {lo[1], 4'b0} : {lo, 3'b0};
    assign lane = rdata >> sh;
    assign mask = (size == SZ_BYTE) ? 32'h0000_00ff : (size == SZ_HALF) ? 32'h0000_ffff : 32'hffff_ffff;
    assign load_val = (size == SZ_BYTE) ? {{24{~uns & lane[7]}}, lane[7:0]} :
                      (size == SZ_HALF) ? {{16{~uns & lane[15]}}, lane[15:0]} : rdata;
    assign merged = (rdata & ~(mask << sh)) | ((wdata & mask) << sh);
    assign misaligned = (req_size == SZ_ILL) || (req_size == SZ_HALF && req_lo[0]) ||
                        (req_size == SZ_WORD && req_lo != 2'b00);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word memory, RMW for sub-word stores.
// Define LSU_RANGE_CHECK_EN to reject addresses beyond the memory depth instead of wrapping.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [31:0]       mem_readdata
);
    state_e             state;
    logic               we_q, uns_q;
    logic [1:0]         size_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q, merged_q, load_val, merged;
    logic               misaligned, bad, full_word;

    lsu_align u_align (
        .size(size_q), .lo(addr_q[1:0]), .uns(uns_q), .rdata(mem_readdata), .wdata(wdata_q),
        .req_size(cpu_size), .req_lo(cpu_addr[1:0]),
        .load_val(load_val), .merged(merged), .misaligned(misaligned)
    );

`ifdef LSU_RANGE_CHECK_EN
    assign bad = misaligned || (|cpu_addr[31:ADDR_W+2]);
`else
    logic unused_hi;
    assign unused_hi = |cpu_addr[31:ADDR_W+2];
    assign bad = misaligned;
`endif

    // Strobes depend only on state and latched request, so reset drops them at once.
    assign full_word     = we_q && size_q == SZ_WORD;
    assign cpu_busy      = state != IDLE;
    assign mem_address   = addr_q[ADDR_W+1:2];
    assign mem_writedata = (state == WRITE) ? merged_q : wdata_q;
    assign mem_memwrite  = (state == ISSUE && full_word) || state == WRITE;
    assign mem_memread   = state == ISSUE && !full_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (state)
                IDLE: if (cpu_req) begin
                    we_q     <= cpu_we;
                    uns_q    <= cpu_unsigned;
                    size_q   <= cpu_size;
                    addr_q   <= cpu_addr[ADDR_W+1:0];
                    wdata_q  <= cpu_wdata;
                    state    <= bad ? ERR : ISSUE;
                    cpu_done <= bad;
                    cpu_err  <= bad;
                    if (bad) cpu_rdata <= '0;
                end
                ISSUE: begin
                    state    <= full_word ? DONE : CAPTURE;
                    cpu_done <= full_word;
                end
                CAPTURE: if (we_q) begin
                    merged_q <= merged;
                    state    <= WRITE;
                end else begin
                    cpu_rdata <= load_val;
                    state     <= DONE;
                    cpu_done  <= 1'b1;
                end
                WRITE: begin
                    state    <= DONE;
                    cpu_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a 1-cycle-latency word memory model.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata, mem_writedata, mem_readdata = '0;
    logic        cpu_done, cpu_err, cpu_busy, mem_memread, mem_memwrite;
    logic [9:0]  mem_address, wr_addr = '0, prev_addr = '0;
    logic        prev_busy = 1'b0;
    logic [31:0] mem [0:1023];
    logic [31:0] last_rd = '0;
    int          nr = 0, nw = 0, checks = 0, errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nr;
        int          nw;
    } exp_t;
    exp_t sb[$];

    load_store_unit #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem[mem_address] <= mem_writedata;
            wr_addr <= mem_address;
            nw++;
        end else if (mem_memread) begin
            mem_readdata <= mem[mem_address];
            nr++;
        end
    end

    always @(negedge clk) begin
        if (cpu_busy) begin
            checks++;
            if (mem_memread && mem_memwrite) begin
                errors++;
                $display("FAIL strobe_excl: read=%b write=%b, required not both", mem_memread, mem_memwrite);
            end
            if (prev_busy && mem_address !== prev_addr) begin
                errors++;
                $display("FAIL addr_stable: got %h, required %h", mem_address, prev_addr);
            end
        end
        prev_busy = cpu_busy;
        prev_addr = mem_address;
    end

    task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic err, input int lat, input int enr, input int enw);
        exp_t e;
        int   n;
        e.rd  = err ? 32'h0 : (we ? last_rd : rd);
        e.err = err;
        e.lat = lat;
        e.nr  = enr;
        e.nw  = enw;
        sb.push_back(e);
        @(negedge clk);
        nr = 0;
        nw = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_done && n < 20);
        e = sb.pop_front();
        last_rd = e.rd;
        checks++;
        if (cpu_done !== 1'b1) begin errors++; $display("FAIL %s done: timeout after %0d cycles", name, n); end
        checks++;
        if (n !== e.lat) begin errors++; $display("FAIL %s latency: got %0d, required %0d", name, n, e.lat); end
        checks++;
        if (cpu_rdata !== e.rd) begin errors++; $display("FAIL %s rdata: got %h, required %h", name, cpu_rdata, e.rd); end
        checks++;
        if (cpu_err !== e.err) begin errors++; $display("FAIL %s err: got %b, required %b", name, cpu_err, e.err); end
        checks++;
        if (nr !== e.nr || nw !== e.nw) begin
            errors++;
            $display("FAIL %s strobes: got rd=%0d wr=%0d, required rd=%0d wr=%0d", name, nr, nw, e.nr, e.nw);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({cpu_rdata, cpu_done, cpu_err, cpu_busy, mem_memread, mem_memwrite} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h done=%b err=%b busy=%b rd=%b wr=%b, required all 0",
                     cpu_rdata, cpu_done, cpu_err, cpu_busy, mem_memread, mem_memwrite);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word;
        do_req("sw_0x10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0, 1);
        checks++;
        if (wr_addr !== 10'd4 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem: got word %0d = %h, required word 4 = deadbeef", wr_addr, mem[4]);
        end
        do_req("lw_0x10", 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 1, 0);
    endtask

    task automatic test_loads;
        mem[4] = 32'h80FF7F01;
        do_req("lb_0x13", 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF80, 0, 3, 1, 0);
        do_req("lbu_0x13", 0, 2'b00, 1, 32'h13, 0, 32'h00000080, 0, 3, 1, 0);
        do_req("lh_0x12", 0, 2'b01, 0, 32'h12, 0, 32'hFFFF80FF, 0, 3, 1, 0);
        do_req("lhu_0x10", 0, 2'b01, 1, 32'h10, 0, 32'h00007F01, 0, 3, 1, 0);
        do_req("lb_0x10", 0, 2'b00, 0, 32'h10, 0, 32'h00000001, 0, 3, 1, 0);
        do_req("lhu_0x12", 0, 2'b01, 1, 32'h12, 0, 32'h000080FF, 0, 3, 1, 0);
    endtask

    task automatic test_subword_store;
        mem[4] = 32'h11223344;
        do_req("sb_0x11", 1, 2'b00, 0, 32'h11, 32'hFFFFFFAA, 0, 0, 4, 1, 1);
        checks++;
        if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL sb_mem: got %h, required 1122aa44", mem[4]); end
        mem[4] = 32'h11223344;
        do_req("sh_0x12", 1, 2'b01, 0, 32'h12, 32'h12345566, 0, 0, 4, 1, 1);
        checks++;
        if (mem[4] !== 32'h55663344) begin errors++; $display("FAIL sh_mem: got %h, required 55663344", mem[4]); end
    endtask

    task automatic test_errors;
        do_req("lw_misalign", 0, 2'b10, 0, 32'h02, 0, 0, 1, 1, 0, 0);
        do_req("sh_misalign", 1, 2'b01, 0, 32'h01, 32'h1234, 0, 1, 1, 0, 0);
        do_req("size_ill", 0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic test_back_to_back;
        int acc = 0, dn = 0, n = 0;
        logic pb = 1'b0;
        exp_t e;
        mem[5] = 32'h0BADF00D;
        e.rd = 32'h0BADF00D; e.err = 0; e.lat = 3; e.nr = 1; e.nw = 0;
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 0; cpu_size = 2'b10; cpu_unsigned = 0; cpu_addr = 32'h14;
        while (dn < 2 && n < 30) begin
            @(negedge clk);
            n++;
            if (cpu_busy && !pb) acc++;
            pb = cpu_busy;
            if (cpu_done) begin
                dn++;
                e = sb.pop_front();
                checks++;
                if (cpu_rdata !== e.rd) begin errors++; $display("FAIL b2b_rdata: got %h, required %h", cpu_rdata, e.rd); end
                if (dn == 2) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_busy && !pb) acc++;
            pb = cpu_busy;
        end
        last_rd = 32'h0BADF00D;
        checks++;
        if (acc !== 2 || dn !== 2) begin errors++; $display("FAIL b2b_accepts: got acc=%0d done=%0d, required 2 and 2", acc, dn); end
    endtask

    task automatic test_req_in_capture;
        int busy_seen = 0;
        mem[6] = 32'h12345678;
        mem[8] = 32'hCAFEF00D;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 32'h18;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1; cpu_size = 2'b10; cpu_addr = 32'h20; cpu_wdata = 32'h0;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL capture_load: got done=%b rdata=%h, required 1 and 12345678", cpu_done, cpu_rdata);
        end
        last_rd = 32'h12345678;
        repeat (4) begin
            @(negedge clk);
            if (cpu_busy) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0 || mem[8] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL capture_ignore: got busy=%0d mem=%h, required 0 and cafef00d", busy_seen, mem[8]);
        end
    endtask

    task automatic test_reset_in_write;
        mem[4] = 32'h11223344;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1; cpu_size = 2'b00; cpu_addr = 32'h11; cpu_wdata = 32'hAA;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_memwrite !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got %b, required 1", mem_memwrite); end
        reset = 1'b1;
        #1;
        checks++;
        if ({cpu_rdata, cpu_done, cpu_err, cpu_busy, mem_memread, mem_memwrite, mem_address, mem_writedata} !== 80'h0) begin
            errors++;
            $display("FAIL rst_outputs: got rdata=%h done=%b err=%b busy=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     cpu_rdata, cpu_done, cpu_err, cpu_busy, mem_memread, mem_memwrite, mem_address, mem_writedata);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rd = 32'h0;
        checks++;
        if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL rst_mem: got %h, required 11223344", mem[4]); end
    endtask

    task automatic test_range;
        mem[0] = 32'h600DCAFE;
`ifdef LSU_RANGE_CHECK_EN
        do_req("lw_range", 0, 2'b10, 0, 32'h1000, 0, 0, 1, 1, 0, 0);
`else
        do_req("lw_wrap", 0, 2'b10, 0, 32'h1000, 0, 32'h600DCAFE, 0, 3, 1, 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset;
        test_word;
        test_loads;
        test_subword_store;
        test_errors;
        test_back_to_back;
        test_req_in_capture;
        test_reset_in_write;
        test_range;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
